// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and defaults for the data-memory port arbiter.
package dmem_arb_pkg;
    localparam int DMEM_AW = 8;
    localparam int DMEM_DW = 8;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef logic owner_t;
endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: combinational 2-way picker, round-robin or fixed priority to port 0.
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    input  logic       rr_en,
    output logic       gnt_valid,
    output owner_t     gnt_idx
);
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = &req ? (rr_en & ~last) : req[1];
    end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: serializes two requesters onto one data memory port, IDLE->ACCESS->DONE.
// Define DMEM_ARB_STATS_EN to add saturating per-port grant counters gcnt0/gcnt1.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW    = DMEM_AW,
    parameter int DW    = DMEM_DW,
    parameter bit RR_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   gcnt0,
    output logic [15:0]   gcnt1
`endif
);
    state_t state;
    owner_t owner, last, gnt_idx;
    logic   lat_we, gnt_valid;

    dmem_rr_pick u_pick (
        .req      ({req1, req0}),
        .last     (last),
        .rr_en    (RR_EN),
        .gnt_valid(gnt_valid),
        .gnt_idx  (gnt_idx)
    );

    // Gating with rst drops a write caught mid-ACCESS by reset.
    assign mem_we = (state == ACCESS) & lat_we & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (gnt_valid) begin
                    state     <= ACCESS;
                    owner     <= gnt_idx;
                    last      <= gnt_idx;
                    lat_we    <= gnt_idx ? we1 : we0;
                    mem_addr  <= gnt_idx ? addr1 : addr0;
                    mem_wdata <= gnt_idx ? wdata1 : wdata0;
                end
                ACCESS: begin
                    state <= DONE;
                    rdata <= lat_we ? rdata : mem_rdata;
                    ack0  <= ~owner;
                    ack1  <= owner;
                end
                default: begin
                    state <= IDLE;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt0 <= '0;
            gcnt1 <= '0;
        end else if (state == IDLE && gnt_valid) begin
            gcnt0 <= (!gnt_idx && gcnt0 != 16'hFFFF) ? gcnt0 + 16'd1 : gcnt0;
            gcnt1 <= (gnt_idx && gcnt1 != 16'hFFFF) ? gcnt1 + 16'd1 : gcnt1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: vector table, tie/reset sequences and randomized traffic vs a transaction model.
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    typedef struct {
        bit         p;
        bit         we;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] rd;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1;
    logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic ack0, ack1, mem_we, f_ack0, f_ack1, f_mem_we;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [7:0] f_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;
    logic [7:0] mem[256] = '{default: 8'h00};
    logic [7:0] f_mem[256] = '{default: 8'h00};
    logic [7:0] ref_mem[256] = '{default: 8'h00};
    int checks = 0, errors = 0;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] gcnt0, gcnt1, f_gcnt0, f_gcnt1;
`endif

    always #5 clk = ~clk;

    assign mem_rdata   = mem[mem_addr];
    assign f_mem_rdata = f_mem[f_mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (f_mem_we) f_mem[f_mem_addr] <= f_mem_wdata;
    end

    dmem_port_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .gcnt0(gcnt0), .gcnt1(gcnt1)
`endif
    );

    dmem_port_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(f_ack0), .ack1(f_ack1), .rdata(f_rdata), .mem_we(f_mem_we),
        .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .gcnt0(f_gcnt0), .gcnt1(f_gcnt1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit p, input bit v, input bit we, input logic [7:0] a, input logic [7:0] d);
        if (p) begin
            req1 = v; we1 = we; addr1 = a; wdata1 = d;
        end else begin
            req0 = v; we0 = we; addr0 = a; wdata0 = d;
        end
    endtask

    // Single transaction from an IDLE negedge, checking every cycle of its latency.
    task automatic txn(input bit p, input bit we, input logic [7:0] a, input logic [7:0] d, input logic [7:0] rd);
        set_req(p, 1'b1, we, a, d);
        @(negedge clk);
        check("acc_mem_we", mem_we, we);
        check("acc_mem_addr", mem_addr, a);
        if (we) check("acc_mem_wdata", mem_wdata, d);
        check("acc_no_ack", {ack1, ack0}, 0);
        @(negedge clk);
        check("done_ack", {ack1, ack0}, p ? 2 : 1);
        check("done_mem_we", mem_we, 0);
        check("done_rdata", rdata, rd);
        set_req(p, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        check("idle_ack", {ack1, ack0}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int seq_rr[$], seq_fp[$];
        int f_ack1_seen, waited;
        bit pend[2];
        bit we_r[2];
        logic [7:0] addr_r[2], d_r[2], model_rd;
        bit last_served, exp_p;

        vecs[0] = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 1'b1, 8'h20, 8'h3C, 8'hA5};
        vecs[3] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h3C};
        vecs[4] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h3C};
        vecs[5] = '{1'b0, 1'b1, 8'hFF, 8'h01, 8'h3C};
        vecs[6] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h01};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h01};
        vecs[7].rd = 8'h00;

        // Reset held two cycles with a write request pending.
        rst = 1'b1;
        set_req(1'b0, 1'b1, 1'b1, 8'h55, 8'h77);
        repeat (2) begin
            @(negedge clk);
            check("rst_ack", {ack1, ack0}, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_rdata", rdata, 0);
        end
        check("rst_no_write", mem[8'h55], 8'h00);
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b0;

        foreach (vecs[i]) begin
            txn(vecs[i].p, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].rd);
            if (vecs[i].we) begin
                ref_mem[vecs[i].a] = vecs[i].d;
                check("vec_mem", mem[vecs[i].a], vecs[i].d);
            end
        end

        // Ties held for four transactions on both the round-robin and fixed-priority arbiters.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
        f_ack1_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (ack0 | ack1) begin
                seq_rr.push_back(int'(ack1));
                check("tie_rr_rdata", rdata, ack1 ? 8'h3C : 8'hA5);
            end
            if (f_ack0) begin
                seq_fp.push_back(0);
                check("tie_fp_rdata", f_rdata, 8'hA5);
            end
            if (f_ack1) f_ack1_seen++;
        end
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        check("tie_rr_count", seq_rr.size(), 4);
        check("tie_fp_count", seq_fp.size(), 4);
        check("tie_fp_starve", f_ack1_seen, 0);
        for (int i = 0; i < 4; i++)
            check("tie_rr_order", (i < seq_rr.size()) ? seq_rr[i] : 9, i % 2);
        @(negedge clk);

        // Reset asserted during the ACCESS cycle of a port-1 write.
        set_req(1'b1, 1'b1, 1'b1, 8'h20, 8'h33);
        @(negedge clk);
        check("rstacc_we_before", mem_we, 1);
        rst = 1'b1;
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("rstacc_we_gated", mem_we, 0);
        @(negedge clk);
        check("rstacc_no_ack", {ack1, ack0}, 0);
        check("rstacc_mem", mem[8'h20], 8'h3C);
        check("rstacc_state", dut.state, IDLE);
        rst = 1'b0;

`ifdef DMEM_ARB_STATS_EN
        check("stats_reset", {gcnt1, gcnt0}, 0);
        repeat (3) txn(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
        repeat (2) txn(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5);
        check("stats_gcnt0", gcnt0, 3);
        check("stats_gcnt1", gcnt1, 2);
`endif

        // Randomized traffic against a transaction-level round-robin model.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pend = '{0, 0};
        last_served = 1'b1;
        model_rd = 8'h00;
        for (int t = 0; t < 80; t++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p]   = 1'b1;
                    we_r[p]   = 1'($urandom_range(0, 1));
                    addr_r[p] = 8'($urandom_range(0, 15));
                    d_r[p]    = 8'($urandom);
                    set_req(1'(p), 1'b1, we_r[p], addr_r[p], d_r[p]);
                end
            end
            if (!pend[0] && !pend[1]) begin
                @(negedge clk);
                continue;
            end
            exp_p = (pend[0] && pend[1]) ? !last_served : pend[1];
            waited = 0;
            while (!(ack0 | ack1) && waited < 8) begin
                @(negedge clk);
                waited++;
            end
            check("rnd_latency", waited, 2);
            check("rnd_port", {ack1, ack0}, exp_p ? 2 : 1);
            if (we_r[exp_p]) ref_mem[addr_r[exp_p]] = d_r[exp_p];
            else model_rd = ref_mem[addr_r[exp_p]];
            check("rnd_rdata", rdata, model_rd);
            last_served = exp_p;
            pend[exp_p] = 1'b0;
            set_req(exp_p, 1'b0, 1'b0, 8'h00, 8'h00);
            @(negedge clk);
        end
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) check("rnd_mem_final", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
